// File: rtl/mem_arbiter_ctrl.sv
// Two-port (instruction/data) memory arbiter onto a single RAM port with
// fair tie-breaking, abort on request drop, per-transaction timeout and sticky error.
module mem_arbiter_ctrl #(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);
    localparam int          CW         = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [1:0]  RAM_ACCESS = 2'd2;
    localparam logic [1:0]  RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

    state_t          r_state;
    logic            r_last_d;
    logic            r_wr;
    logic [31:0]     r_addr;
    logic [31:0]     r_store;
    logic [31:0]     r_iload;
    logic [31:0]     r_dload;
    logic [CW-1:0]   r_cnt;
    logic            r_err;

    logic            w_pend_d;
    logic            w_hold;
    logic            w_acc;
    logic            w_fail;
    logic            w_done;
    logic            w_grant_d;
    logic [31:0]     w_rdata;

    assign w_pend_d  = dREN | dWEN;
    // The served side must still be requesting; otherwise the transaction is aborted.
    assign w_hold    = (r_state == SERVE_I) ? iREN :
                       (r_state == SERVE_D) ? w_pend_d : 1'b0;
    assign w_acc     = w_hold && (ramstate == RAM_ACCESS);
    assign w_fail    = w_hold && !w_acc && ((ramstate == RAM_ERROR) || (r_cnt == CNT_LAST));
    assign w_done    = w_acc | w_fail;
    assign w_rdata   = w_acc ? ramload : ERR_WORD;
    assign w_grant_d = w_pend_d && (!iREN || !r_last_d);

    assign ramREN   = w_hold && ((r_state == SERVE_I) || !r_wr);
    assign ramWEN   = w_hold && (r_state == SERVE_D) && r_wr;
    assign ramaddr  = r_addr;
    assign ramstore = r_store;
    assign iwait    = !((r_state == SERVE_I) && w_done);
    assign dwait    = !((r_state == SERVE_D) && w_done);
    assign iload    = ((r_state == SERVE_I) && w_done) ? w_rdata : r_iload;
    assign dload    = ((r_state == SERVE_D) && w_done && !r_wr) ? w_rdata : r_dload;
    assign err      = r_err;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= IDLE;
            r_last_d <= 1'b0;
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_store  <= '0;
            r_iload  <= '0;
            r_dload  <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_grant_d) begin
                        r_state  <= SERVE_D;
                        r_addr   <= daddr;
                        r_wr     <= dWEN;
                        r_store  <= dstore;
                        r_last_d <= 1'b1;
                    end else if (iREN) begin
                        r_state  <= SERVE_I;
                        r_addr   <= iaddr;
                        r_wr     <= 1'b0;
                        r_last_d <= 1'b0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (!w_hold || w_done)
                        r_state <= IDLE;
                    if (w_fail)
                        r_err <= 1'b1;
                    if (w_done && (r_state == SERVE_I))
                        r_iload <= w_rdata;
                    if (w_done && (r_state == SERVE_D) && !r_wr)
                        r_dload <= w_rdata;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed bench for mem_arbiter_ctrl: reset, reads, writes, fairness,
// timeout, RAM error, abort and mid-transaction reset.
module tb_mem_arbiter_ctrl;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, RERR = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    mem_arbiter_ctrl #(.TIMEOUT(16), .ERR_WORD(32'hBAD1BAD1)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic cyc();
        @(negedge CLK);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        nRST = 1'b0;
        iREN = $urandom_range(1); dREN = $urandom_range(1); dWEN = $urandom_range(1);
        iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
        ramstate = 2'($urandom_range(3));
        #12;
        check_eq("rst_iwait", {31'd0, iwait}, 32'd1);
        check_eq("rst_dwait", {31'd0, dwait}, 32'd1);
        check_eq("rst_ramREN", {31'd0, ramREN}, 32'd0);
        check_eq("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        check_eq("rst_iload", iload, 32'd0);
        check_eq("rst_dload", dload, 32'd0);
        check_eq("rst_ramaddr", ramaddr, 32'd0);
        check_eq("rst_ramstore", ramstore, 32'd0);

        // Tie from reset: data first, then instruction, then data again.
        iREN = 1; iaddr = 32'h100; dREN = 1; dWEN = 0; daddr = 32'h200; dstore = 0;
        ramstate = FREE; ramload = 0;
        cyc(); nRST = 1'b1; settle();
        check_eq("tie_idle_ren", {31'd0, ramREN}, 32'd0);
        cyc(); ramstate = ACCESS; ramload = 32'h11; settle();
        check_eq("tie1_addr", ramaddr, 32'h200);
        check_eq("tie1_dwait", {31'd0, dwait}, 32'd0);
        check_eq("tie1_iwait", {31'd0, iwait}, 32'd1);
        check_eq("tie1_dload", dload, 32'h11);
        cyc(); ramstate = FREE; settle();
        check_eq("tie_gap_ren", {31'd0, ramREN}, 32'd0);
        check_eq("tie_gap_dload", dload, 32'h11);
        cyc(); ramstate = ACCESS; ramload = 32'h22; settle();
        check_eq("tie2_addr", ramaddr, 32'h100);
        check_eq("tie2_iwait", {31'd0, iwait}, 32'd0);
        check_eq("tie2_dwait", {31'd0, dwait}, 32'd1);
        check_eq("tie2_iload", iload, 32'h22);
        cyc(); ramstate = FREE; settle();
        cyc(); ramstate = ACCESS; ramload = 32'h33; settle();
        check_eq("tie3_addr", ramaddr, 32'h200);
        check_eq("tie3_dwait", {31'd0, dwait}, 32'd0);
        cyc(); ramstate = FREE; iREN = 0; dREN = 0; settle();

        // Instruction read, ACCESS two cycles after ramREN rises.
        cyc(); iREN = 1; iaddr = 32'h40; settle();
        check_eq("ird_idle_iwait", {31'd0, iwait}, 32'd1);
        cyc(); ramstate = BUSY; settle();
        check_eq("ird_ramREN", {31'd0, ramREN}, 32'd1);
        check_eq("ird_ramaddr", ramaddr, 32'h40);
        check_eq("ird_wait1", {31'd0, iwait}, 32'd1);
        cyc(); settle();
        check_eq("ird_wait2", {31'd0, iwait}, 32'd1);
        cyc(); ramstate = ACCESS; ramload = 32'h8C010004; settle();
        check_eq("ird_iwait", {31'd0, iwait}, 32'd0);
        check_eq("ird_iload", iload, 32'h8C010004);
        cyc(); ramstate = FREE; iREN = 0; settle();
        check_eq("ird_after_iwait", {31'd0, iwait}, 32'd1);
        check_eq("ird_hold_iload", iload, 32'h8C010004);
        check_eq("ird_after_ren", {31'd0, ramREN}, 32'd0);

        // Data write.
        cyc(); dWEN = 1; daddr = 32'h3100; dstore = 32'hDEADBEEF; settle();
        cyc(); ramstate = BUSY; settle();
        check_eq("dwr_ramWEN", {31'd0, ramWEN}, 32'd1);
        check_eq("dwr_ramREN", {31'd0, ramREN}, 32'd0);
        check_eq("dwr_ramaddr", ramaddr, 32'h3100);
        check_eq("dwr_ramstore", ramstore, 32'hDEADBEEF);
        check_eq("dwr_busy_dwait", {31'd0, dwait}, 32'd1);
        cyc(); ramstate = ACCESS; ramload = 32'h77; settle();
        check_eq("dwr_dwait", {31'd0, dwait}, 32'd0);
        check_eq("dwr_iwait", {31'd0, iwait}, 32'd1);
        check_eq("dwr_dload_kept", dload, 32'h33);
        cyc(); ramstate = FREE; dWEN = 0; settle();
        check_eq("dwr_after_wen", {31'd0, ramWEN}, 32'd0);

        // Timeout: RAM stuck BUSY.
        cyc(); dREN = 1; daddr = 32'h500; ramstate = BUSY; settle();
        for (int k = 1; k <= 15; k++) begin
            cyc(); settle();
            check_eq($sformatf("tmo_wait_c%0d", k), {31'd0, dwait}, 32'd1);
        end
        cyc(); settle();
        check_eq("tmo_dwait", {31'd0, dwait}, 32'd0);
        check_eq("tmo_dload", dload, 32'hBAD1BAD1);
        check_eq("tmo_err_pre", {31'd0, err}, 32'd0);
        cyc(); dREN = 0; ramstate = FREE; settle();
        check_eq("tmo_err", {31'd0, err}, 32'd1);
        check_eq("tmo_dload_hold", dload, 32'hBAD1BAD1);
        check_eq("tmo_dwait_after", {31'd0, dwait}, 32'd1);

        // Immediate RAM error completion on the instruction side.
        cyc(); iREN = 1; iaddr = 32'h80; settle();
        cyc(); ramstate = RERR; settle();
        check_eq("rerr_iwait", {31'd0, iwait}, 32'd0);
        check_eq("rerr_iload", iload, 32'hBAD1BAD1);
        cyc(); ramstate = FREE; iREN = 0; settle();
        check_eq("rerr_err_sticky", {31'd0, err}, 32'd1);

        // Abort: data request dropped mid-serve.
        cyc(); dREN = 1; daddr = 32'h600; settle();
        cyc(); ramstate = BUSY; settle();
        check_eq("abt_ramREN", {31'd0, ramREN}, 32'd1);
        cyc(); dREN = 0; settle();
        check_eq("abt_ramREN_low", {31'd0, ramREN}, 32'd0);
        check_eq("abt_dwait", {31'd0, dwait}, 32'd1);
        cyc(); ramstate = ACCESS; ramload = 32'h99; settle();
        check_eq("abt_idle_dwait", {31'd0, dwait}, 32'd1);
        check_eq("abt_idle_ren", {31'd0, ramREN}, 32'd0);
        check_eq("abt_dload", dload, 32'hBAD1BAD1);
        ramstate = FREE;

        // Reset in the middle of an instruction read, then a fresh read.
        cyc(); iREN = 1; iaddr = 32'h44; settle();
        cyc(); ramstate = BUSY; settle();
        check_eq("mrst_pre_ren", {31'd0, ramREN}, 32'd1);
        nRST = 1'b0; settle();
        check_eq("mrst_ren", {31'd0, ramREN}, 32'd0);
        check_eq("mrst_iwait", {31'd0, iwait}, 32'd1);
        check_eq("mrst_err", {31'd0, err}, 32'd0);
        check_eq("mrst_iload", iload, 32'd0);
        check_eq("mrst_ramaddr", ramaddr, 32'd0);
        cyc(); nRST = 1'b1; settle();
        cyc(); ramstate = ACCESS; ramload = 32'h55; settle();
        check_eq("mrst_new_addr", ramaddr, 32'h44);
        check_eq("mrst_new_iwait", {31'd0, iwait}, 32'd0);
        check_eq("mrst_new_iload", iload, 32'h55);
        check_eq("mrst_new_err", {31'd0, err}, 32'd0);
        cyc(); iREN = 0; ramstate = FREE; settle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
